// File: rtl/proc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : proc_seq_ctrl
// Description : Host-facing sequencer for the matrix processor. Accepts a
//               command, buffers eight operand words, drives contiguous
//               en_inst / en_data / en_wb bursts into the processor, captures
//               the result words and streams them back with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_seq_ctrl #(
    parameter int DW         = 32,  // must be 32: the processor is fixed 32b
    parameter int GAP_CYCLES = 1    // idle cycles between en_data and en_wb, >= 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic          opd_valid,
    output logic          opd_ready,
    input  logic [DW-1:0] opd_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_last,
    output logic          busy,
    output logic          err,
    output logic [31:0]   proc_data_in,
    output logic          proc_en_inst,
    output logic          proc_en_data,
    output logic          proc_en_wb,
    input  logic [31:0]   proc_data_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_INST = 3'd2,
        S_DATA = 3'd3,
        S_GAP  = 3'd4,
        S_WB   = 3'd5,
        S_OUT  = 3'd6
    } state_t;

    localparam int               c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       c_OP_DEL   = 3'd4;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_op;
    logic [2:0]           r_cnt;      // shared word index for LOAD/DATA/WB/OUT
    logic [c_GAP_W-1:0]   r_gap;
    logic [DW-1:0]        r_obuf [8];
    logic [31:0]          r_rbuf [4];
    logic                 r_err;
    logic                 w_cnt_step;
    logic                 w_cmd_ok;
    logic                 w_cmd_bad;
    logic [1:0]           w_res_last_idx;

    // A command is only looked at while IDLE; opcodes above del are rejected.
    assign w_cmd_ok       = (r_state == S_IDLE) && cmd_valid && (cmd_op <= c_OP_DEL);
    assign w_cmd_bad      = (r_state == S_IDLE) && cmd_valid && (cmd_op >  c_OP_DEL);
    // del produces a single scalar, every other op a full 2x2 result.
    assign w_res_last_idx = (r_op == c_OP_DEL) ? 2'd0 : 2'd3;
    assign err            = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and all handshake / processor-side outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_step   = 1'b0;
        cmd_ready    = 1'b0;
        opd_ready    = 1'b0;
        res_valid    = 1'b0;
        res_data     = '0;
        res_last     = 1'b0;
        busy         = 1'b1;
        proc_data_in = 32'd0;
        proc_en_inst = 1'b0;
        proc_en_data = 1'b0;
        proc_en_wb   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy      = 1'b0;
                // Held low while rst is asserted so the reset cycle shows all outputs at 0.
                cmd_ready = ~rst;
                if (w_cmd_ok) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                opd_ready  = 1'b1;
                w_cnt_step = opd_valid;
                if (opd_valid && (r_cnt == 3'd7)) begin
                    w_state_nxt = S_INST;
                end
            end
            S_INST: begin
                proc_en_inst = 1'b1;
                proc_data_in = {r_op, 29'd0};
                w_state_nxt  = S_DATA;
            end
            S_DATA: begin
                // The processor restarts its index if en_data drops, so this
                // burst always runs all eight cycles back to back.
                proc_en_data = 1'b1;
                proc_data_in = r_obuf[r_cnt];
                w_cnt_step   = 1'b1;
                if (r_cnt == 3'd7) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB: begin
                proc_en_wb = 1'b1;
                w_cnt_step = 1'b1;
                if (r_cnt == 3'd3) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                res_valid  = 1'b1;
                res_data   = r_rbuf[r_cnt[1:0]];
                res_last   = (r_cnt[1:0] == w_res_last_idx);
                w_cnt_step = res_ready;
                if (res_ready && res_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Opcode latch, word index, gap timer, operand/result buffers and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= 3'd0;
            r_cnt <= 3'd0;
            r_gap <= '0;
            r_err <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_obuf[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                r_rbuf[i] <= 32'd0;
            end
        end else begin
            r_err <= w_cmd_bad;

            if (w_cmd_ok) begin
                r_op <= cmd_op;
            end

            // Index restarts on every state change so each phase counts from 0.
            if (r_state != w_state_nxt) begin
                r_cnt <= 3'd0;
            end else if (w_cnt_step) begin
                r_cnt <= r_cnt + 3'd1;
            end

            if (r_state == S_GAP) begin
                r_gap <= r_gap + c_GAP_W'(1);
            end else begin
                r_gap <= '0;
            end

            if ((r_state == S_LOAD) && opd_valid) begin
                r_obuf[r_cnt] <= opd_data;
            end

            if (r_state == S_WB) begin
                r_rbuf[r_cnt[1:0]] <= proc_data_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_proc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_seq_ctrl
// Description : Directed self-checking bench for proc_seq_ctrl with a small
//               behavioural model of the matrix processor on the proc_* side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic        opd_valid;
    logic        opd_ready;
    logic [31:0] opd_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_last;
    logic        busy;
    logic        err;
    logic [31:0] proc_data_in;
    logic        proc_en_inst;
    logic        proc_en_data;
    logic        proc_en_wb;
    logic [31:0] proc_data_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] v_ops [8];
    logic [31:0] v_exp [4];

    proc_seq_ctrl #(.DW(32), .GAP_CYCLES(1)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .opd_valid     (opd_valid),
        .opd_ready     (opd_ready),
        .opd_data      (opd_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_last      (res_last),
        .busy          (busy),
        .err           (err),
        .proc_data_in  (proc_data_in),
        .proc_en_inst  (proc_en_inst),
        .proc_en_data  (proc_en_data),
        .proc_en_wb    (proc_en_wb),
        .proc_data_out (proc_data_out)
    );

    always #5 clk = ~clk;

    // ---------------- processor model ----------------
    logic [2:0]  m_op;
    logic [31:0] m_r [8];
    logic [2:0]  m_idx;
    logic [1:0]  m_widx;
    logic [31:0] m_res [4];

    always @(posedge clk) begin
        if (rst) begin
            m_op   <= 3'd0;
            m_idx  <= 3'd0;
            m_widx <= 2'd0;
            for (int i = 0; i < 8; i++) m_r[i] <= 32'd0;
        end else begin
            if (proc_en_inst) m_op <= proc_data_in[31:29];
            if (proc_en_data) begin
                m_r[m_idx] <= proc_data_in;
                m_idx      <= m_idx + 3'd1;
            end else begin
                m_idx <= 3'd0;
            end
            if (proc_en_wb) m_widx <= m_widx + 2'd1;
            else            m_widx <= 2'd0;
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) m_res[j] = 32'd0;
        case (m_op)
            3'd0: for (int j = 0; j < 4; j++) m_res[j] = m_r[j] + m_r[j+4];
            3'd1: for (int j = 0; j < 4; j++) m_res[j] = m_r[j] - m_r[j+4];
            3'd2: begin
                m_res[0] = m_r[0]*m_r[4] + m_r[1]*m_r[6];
                m_res[1] = m_r[0]*m_r[5] + m_r[1]*m_r[7];
                m_res[2] = m_r[2]*m_r[4] + m_r[3]*m_r[6];
                m_res[3] = m_r[2]*m_r[5] + m_r[3]*m_r[7];
            end
            3'd3: begin
                m_res[0] = m_r[0];
                m_res[1] = m_r[2];
                m_res[2] = m_r[1];
                m_res[3] = m_r[3];
            end
            3'd4: m_res[0] = m_r[0]*m_r[3] - m_r[1]*m_r[2];
            default: ;
        endcase
    end

    assign proc_data_out = m_res[m_widx];

    // ---------------- bus monitors ----------------
    int run_cur  = 0;
    int run_last = 0;
    int overlap  = 0;
    int pdi_bad  = 0;

    always @(posedge clk) begin
        if (proc_en_data) begin
            run_cur <= run_cur + 1;
        end else if (run_cur != 0) begin
            run_last <= run_cur;
            run_cur  <= 0;
        end
    end

    always @(negedge clk) begin
        if ((int'(proc_en_inst) + int'(proc_en_data) + int'(proc_en_wb)) > 1) overlap <= overlap + 1;
        if (!proc_en_inst && !proc_en_data && (proc_data_in != 32'd0)) pdi_bad <= pdi_bad + 1;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue a command and feed the eight operands; returns at the negedge of the INST cycle.
    task automatic load_txn(input logic [2:0] op, input bit toggle);
        int t;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        opd_valid = 1'b1;            // stray word while IDLE must be ignored
        opd_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        cmd_valid = 1'b0;
        opd_valid = 1'b0;
        chk("busy_after_cmd", busy, 1);
        for (int k = 0; k < 8; k++) begin
            opd_valid = 1'b1;
            opd_data  = v_ops[k];
            t = 0;
            while (!opd_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t >= 20) begin
                chk("opd_ready_timeout", 0, 1);
                opd_valid = 1'b0;
                return;
            end
            @(negedge clk);
            opd_valid = 1'b0;
            if (toggle && k != 7) @(negedge clk);
        end
        chk("en_inst", proc_en_inst, 1);
        chk("inst_word", proc_data_in, {op, 29'd0});
    endtask

    task automatic run_txn(input logic [2:0] op, input int nres, input bit toggle, input bit stall);
        int t;
        load_txn(op, toggle);
        t = 0;
        while (!res_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("first_res_latency", t, 14);
        for (int i = 0; i < nres; i++) begin
            if (stall && i == 1) begin
                repeat (5) @(negedge clk);
                chk("stall_valid", res_valid, 1);
            end
            chk("res_data", res_data, v_exp[i]);
            chk("res_last", res_last, (i == nres-1) ? 1 : 0);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        chk("res_valid_done", res_valid, 0);
        chk("busy_done", busy, 0);
        chk("data_run_len", run_last, 8);
        if (toggle) begin
            for (int k = 0; k < 8; k++) chk("proc_data_order", m_r[k], v_ops[k]);
        end
    endtask

    task automatic set_ops(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        v_ops[0] = a0; v_ops[1] = a1; v_ops[2] = a2; v_ops[3] = a3;
        v_ops[4] = a4; v_ops[5] = a5; v_ops[6] = a6; v_ops[7] = a7;
    endtask

    task automatic set_exp(input logic [31:0] e0, e1, e2, e3);
        v_exp[0] = e0; v_exp[1] = e1; v_exp[2] = e2; v_exp[3] = e3;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; opd_valid = 1'b0;
        opd_data = 32'd0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_pdi", proc_data_in, 0);
        chk("rst_en", {proc_en_inst, proc_en_data, proc_en_wb}, 0);

        // add with a 5-cycle result stall
        set_ops(1, 2, 3, 4, 5, 6, 7, 8);  set_exp(6, 8, 10, 12);
        run_txn(3'd0, 4, 1'b0, 1'b1);
        // mul
        set_ops(1, 2, 3, 4, 5, 6, 7, 8);  set_exp(19, 22, 43, 50);
        run_txn(3'd2, 4, 1'b0, 1'b0);
        // sub
        set_ops(10, 20, 30, 40, 1, 2, 3, 4); set_exp(9, 18, 27, 36);
        run_txn(3'd1, 4, 1'b0, 1'b0);
        // trans with opd_valid toggled during load
        set_ops(1, 2, 3, 4, 0, 0, 0, 0);  set_exp(1, 3, 2, 4);
        run_txn(3'd3, 4, 1'b1, 1'b0);
        // del: single word
        set_ops(1, 2, 3, 4, 9, 9, 9, 9);  set_exp(32'hFFFF_FFFE, 0, 0, 0);
        run_txn(3'd4, 1, 1'b0, 1'b0);

        // illegal opcode
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd6;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_cmd_ready", cmd_ready, 1);
        chk("err_busy", busy, 0);
        chk("err_no_inst", proc_en_inst, 0);
        @(negedge clk);
        chk("err_one_cycle", err, 0);
        chk("err_still_idle", busy, 0);

        // reset in the 4th DATA cycle
        set_ops(1, 2, 3, 4, 5, 6, 7, 8);
        load_txn(3'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("mid_data_en", proc_en_data, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_en", {proc_en_inst, proc_en_data, proc_en_wb}, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_res_valid", res_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        set_exp(6, 8, 10, 12);
        run_txn(3'd0, 4, 1'b0, 1'b0);

        chk("no_enable_overlap", overlap, 0);
        chk("pdi_zero_outside", pdi_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
